// File: rtl/mult_div_if.sv
// E-stage request bus of the multiply/divide unit and the HI/LO/Busy values it returns.
interface mult_div_if;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDUOp, A, B, input Busy, HI, LO);
  modport slave  (input Start, MDUOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; the result is computed at issue
// and held back until the busy count expires, so HI/LO never show a partial value.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
  } mdu_op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_wb_en;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  mdu_op_e     w_op;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic        w_b_zero;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic [3:0]  w_cycles;
  logic        w_is_long;

  assign w_op     = mdu_op_e'(bus.MDUOp);
  assign w_b_zero = (bus.B == 32'd0);

  assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Signed divide on magnitudes: sidesteps the INT_MIN / -1 overflow and keeps
  // the remainder's sign tied to the dividend.
  assign w_a_mag = bus.A[31] ? (32'd0 - bus.A) : bus.A;
  assign w_b_mag = bus.B[31] ? (32'd0 - bus.B) : bus.B;
  assign w_q_mag = w_b_zero ? 32'd0 : w_a_mag / w_b_mag;
  assign w_r_mag = w_b_zero ? 32'd0 : w_a_mag % w_b_mag;
  assign w_q_u   = w_b_zero ? 32'd0 : bus.A / bus.B;
  assign w_r_u   = w_b_zero ? 32'd0 : bus.A % bus.B;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_res_hi  = 32'd0;
    w_res_lo  = 32'd0;
    w_cycles  = 4'(MULT_CYCLES);
    w_is_long = 1'b1;
    case (w_op)
      OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      OP_DIV: begin
        w_cycles = 4'(DIV_CYCLES);
        w_res_lo = (bus.A[31] ^ bus.B[31]) ? (32'd0 - w_q_mag) : w_q_mag;
        w_res_hi = bus.A[31] ? (32'd0 - w_r_mag) : w_r_mag;
      end
      OP_DIVU: begin
        w_cycles = 4'(DIV_CYCLES);
        w_res_lo = w_q_u;
        w_res_hi = w_r_u;
      end
      default: w_is_long = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_wb_en  <= 1'b0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            if (w_is_long) begin
              r_res_hi <= w_res_hi;
              r_res_lo <= w_res_lo;
              r_cnt    <= w_cycles;
              // Divide by zero still burns the busy period but skips writeback.
              r_wb_en  <= !(w_b_zero && (w_op == OP_DIV || w_op == OP_DIVU));
              r_state  <= S_BUSY;
            end else if (w_op == OP_MTHI) begin
              r_hi <= bus.A;
            end else if (w_op == OP_MTLO) begin
              r_lo <= bus.A;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_wb_en) begin
              r_hi <= r_res_hi;
              r_lo <= r_res_lo;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy = (r_state == S_BUSY);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO and busy lengths.
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   n_busy;

  mult_div_if bus ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Caller is mid-cycle; the op is sampled at the next rising edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.MDUOp = 3'd0;
  endtask

  // Counts busy cycles; returns at the negedge of the first idle cycle.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.Busy) return;
      n++;
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_idle_timeout busy=%0d cycles, required idle within 40", n);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.MDUOp = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // mult -2 * 3
    start_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle(n_busy);
    check("mult_busy", n_busy, 5);
    check("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo", bus.LO, 32'hFFFF_FFFA);

    // multu, same operands, back-to-back
    start_op(3'd2, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle(n_busy);
    check("multu_busy", n_busy, 5);
    check("multu_hi", bus.HI, 32'h0000_0002);
    check("multu_lo", bus.LO, 32'hFFFF_FFFA);

    // div -7 / 2
    start_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_hold_hi", bus.HI, 32'h0000_0002);
    wait_idle(n_busy);
    check("div_busy", n_busy, 10);
    check("div_lo", bus.LO, 32'hFFFF_FFFD);
    check("div_hi", bus.HI, 32'hFFFF_FFFF);

    start_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n_busy);
    check("divu_busy", n_busy, 10);
    check("divu_lo", bus.LO, 32'h7FFF_FFFC);
    check("divu_hi", bus.HI, 32'h0000_0001);

    start_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n_busy);
    check("divovf_lo", bus.LO, 32'h8000_0000);
    check("divovf_hi", bus.HI, 32'h0000_0000);

    // Preload, then divide by zero leaves HI/LO alone
    start_op(3'd5, 32'h0000_0011, 32'd0);
    check("mthi_hi", bus.HI, 32'h0000_0011);
    check("mthi_busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge clk);
    start_op(3'd6, 32'h0000_0022, 32'd0);
    check("mtlo_lo", bus.LO, 32'h0000_0022);
    @(negedge clk);
    start_op(3'd3, 32'h0000_0050, 32'd0);
    wait_idle(n_busy);
    check("div0_busy", n_busy, 10);
    check("div0_hi", bus.HI, 32'h0000_0011);
    check("div0_lo", bus.LO, 32'h0000_0022);
    start_op(3'd1, 32'd3, 32'd4);
    wait_idle(n_busy);
    check("b2b_busy", n_busy, 5);
    check("b2b_lo", bus.LO, 32'h0000_000C);
    check("b2b_hi", bus.HI, 32'h0000_0000);

    // mthi during busy cycle 2 is ignored
    start_op(3'd1, 32'd7, 32'd9);
    @(negedge clk);
    @(negedge clk);
    start_op(3'd5, 32'hDEAD_BEEF, 32'd0);
    wait_idle(n_busy);
    check("ign_busy_rest", n_busy, 3);
    check("ign_hi", bus.HI, 32'h0000_0000);
    check("ign_lo", bus.LO, 32'h0000_003F);

    start_op(3'd6, 32'h0000_1234, 32'd0);
    check("mtlo_idle_lo", bus.LO, 32'h0000_1234);
    check("mtlo_idle_busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge clk);
    check("mtlo_idle_busy2", {31'd0, bus.Busy}, 32'd0);

    // Asynchronous reset in busy cycle 3 of a div
    start_op(3'd5, 32'h0000_0055, 32'd0);
    @(negedge clk);
    start_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.Busy}, 32'd0);
    check("arst_hi", bus.HI, 32'd0);
    check("arst_lo", bus.LO, 32'd0);
    #1 reset = 1'b0;
    n_busy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.Busy || bus.HI != 32'd0 || bus.LO != 32'd0) n_busy++;
    end
    check("post_rst_quiet", n_busy, 0);
    check("post_rst_hi", bus.HI, 32'd0);
    check("post_rst_lo", bus.LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit for the five-stage pipeline, sitting in the E stage beside the ALU and owning the architectural HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo from the E stage. It runs multi-cycle operations against a down-counter and reports `Busy`. The hazard controller consumes `Start | Busy` to stall any D-stage HI/LO instruction; this block is the responder end of that stall handshake. mfhi/mflo read `HI`/`LO` directly, with the E-stage result mux selecting between them.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `Start` input, 1 bit: a valid MDU instruction is in E this cycle; qualifies `MDUOp`.
- `MDUOp` input, 3 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- `A` input, 32 bits: forwarded rs value (dividend / multiplicand / mthi-mtlo source).
- `B` input, 32 bits: forwarded rt value (divisor / multiplier).
- `Busy` output, 1 bit: registered; high while an operation is in flight.
- `HI` output, 32 bits: architectural HI register.
- `LO` output, 32 bits: architectural LO register.

## Operation
- State: `cnt` (4 bits), `busy_q`, pending `res_hi`/`res_lo` (32 bits each), and the `HI`/`LO` registers.
- **IDLE (`busy_q`=0).**
  - `Start` with op 1–4: compute the full result from `A`/`B` and latch it into `res_hi`/`res_lo`. Load `cnt` with MULT_CYCLES or DIV_CYCLES, set `busy_q`=1, and go to BUSY.
  - `Start` with op 5: `HI`<=`A` at the next edge.
  - `Start` with op 6: `LO`<=`A` at the next edge.
  - Ops 5 and 6 never raise `Busy`.
  - Op 0 or 7, or `Start`=0: no change.
- **BUSY.**
  - `cnt` decrements each edge.
  - On the edge where `cnt`==1: `HI`<=`res_hi`, `LO`<=`res_lo`, `busy_q`<=0, and return to IDLE.
- **`Start` while BUSY.** Any op is ignored: no HI/LO change, no restart. The hazard controller guarantees this never occurs, but the block must tolerate it.
- **mult.** Signed 32x32 product to 64 bits; HI = upper word, LO = lower word.
- **multu.** Same as mult, unsigned.
- **div.** Signed, quotient truncates toward zero; LO = quotient, HI = remainder; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **divu.** Unsigned; LO = quotient, HI = remainder.
- **Divide by zero (B==0, div or divu).** The full busy period still elapses, but the final edge leaves `HI`/`LO` unchanged, matching MARS.
- **Reset.** Asynchronous; forces `HI`=0, `LO`=0, `Busy`=0, `cnt`=0 and discards the pending result.
  - Reset mid-operation aborts the operation; no late writeback follows deassertion.

## Timing
- Reset values: `Busy`=0, `HI`=0x00000000, `LO`=0x00000000.
- `Start` is sampled at the rising edge that ends cycle t.
- For op 1–4 with N cycles:
  - `Busy`=1 during cycles t+1 .. t+N.
  - `HI`/`LO` update at the edge ending cycle t+N.
  - New values are visible and `Busy`=0 in cycle t+N+1.
- mthi/mtlo: value visible in `HI`/`LO` at cycle t+1; `Busy` stays 0.
- Back-to-back operations: a `Start` in cycle t+N+1 is accepted. There is no dead cycle.
- `HI`/`LO` change only on the edges described above. They are stable throughout BUSY, so a stalled mfhi/mflo never sees a partial result.
- Stall contract: the hazard controller stalls D when (`Start` | `Busy`) and D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo. This block depends on that contract only for architectural correctness, not for internal safety.

## Test plan
- **mult** with A=0xFFFFFFFE, B=0x00000003: `Busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **multu** with the same operands: HI=0x00000002, LO=0xFFFFFFFA, after 5 busy cycles.
- **div/divu** with A=0xFFFFFFF9, B=0x00000002:
  - div: `Busy` 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu: LO=0x7FFFFFFC, HI=0x00000001.
  - Also check 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Divide by zero and back-to-back.** Preload HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0: `Busy` 10 cycles, HI/LO remain 0x11/0x22. Then issue mult 3×4 in the first idle cycle: LO=0x0000000C, HI=0 after 5 cycles.
- **Ignored starts.** Issue mthi A=0xDEADBEEF in cycle 2 of a mult busy period: ignored, and HI ends with the mult result. Then mtlo A=0x1234 while idle: LO=0x1234 next cycle, `Busy` never asserted.
- **Reset mid-operation.** Assert `reset` asynchronously in busy cycle 3 of a div, off a clock edge: `Busy`, HI, LO go to 0 immediately. After deassertion they stay 0 with no writeback.
